// File: rtl/exe_cdb_arb.sv
// ---------------------------------------------------------------------------
// exe_cdb_arb
//   Common-data-bus writeback arbiter. Up to CH execution units (ALU, DIV,
//   FPU, FDIV, CSR, MEM, ...) compete for a single registered broadcast
//   stage. One channel is granted per cycle whenever the broadcast stage is
//   free, and its tag/data appear on the bus on the following edge.
//
// Parameters
//   DATA  writeback data width per channel
//   TAG   reorder-buffer tag width
//   CH    number of writeback channels (2..16)
//   RR    1 = round-robin, 0 = fixed priority (lowest index wins)
//
// Ports
//   clk        clock, all state on the rising edge
//   reset      synchronous, active-high
//   wb_req_    per-channel request, active-low
//   wb_tag     per-channel tag,  channel i at [i*TAG  +: TAG]
//   wb_data    per-channel data, channel i at [i*DATA +: DATA]
//   wb_ack_    per-channel grant, active-low, combinational, one-hot-low
//   cdb_stall  consumer back-pressure, active-high
//   cdb_valid  registered bus valid
//   cdb_tag    registered broadcast tag
//   cdb_data   registered broadcast data
//   cdb_src    registered index of the granted channel
// ---------------------------------------------------------------------------
module exe_cdb_arb #(
    parameter int DATA = 32,
    parameter int TAG  = 6,
    parameter int CH   = 6,
    parameter int RR   = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [CH-1:0]            wb_req_,
    input  logic [CH*TAG-1:0]        wb_tag,
    input  logic [CH*DATA-1:0]       wb_data,
    output logic [CH-1:0]            wb_ack_,
    input  logic                     cdb_stall,
    output logic                     cdb_valid,
    output logic [TAG-1:0]           cdb_tag,
    output logic [DATA-1:0]          cdb_data,
    output logic [$clog2(CH)-1:0]    cdb_src
);

    localparam int SW = $clog2(CH);

    logic [CH-1:0] req;
    logic          free;
    logic          gnt_any;
    logic [SW-1:0] gnt_idx;
    logic [SW-1:0] ptr;

    assign req  = ~wb_req_;
    // A held broadcast only blocks new grants while the consumer stalls it.
    assign free = !cdb_valid || !cdb_stall;

    // Round-robin as a two-pass priority search: first the channels at or
    // above ptr, then wrap around from channel 0. In fixed mode the first
    // pass already covers every channel, so the second never fires.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        if (!reset && free) begin
            for (int i = 0; i < CH; i++) begin
                if (!gnt_any && req[i] && (RR == 0 || i >= int'(ptr))) begin
                    gnt_any = 1'b1;
                    gnt_idx = SW'(i);
                end
            end
            for (int i = 0; i < CH; i++) begin
                if (!gnt_any && req[i]) begin
                    gnt_any = 1'b1;
                    gnt_idx = SW'(i);
                end
            end
        end
    end

    always_comb begin
        wb_ack_ = '1;
        if (gnt_any) wb_ack_[gnt_idx] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_data  <= '0;
            cdb_src   <= '0;
            ptr       <= '0;
        end else if (free) begin
            cdb_valid <= gnt_any;
            // Payload registers only move on a grant; an idle free cycle
            // just drops valid and leaves the last broadcast visible.
            if (gnt_any) begin
                cdb_tag  <= wb_tag[gnt_idx*TAG +: TAG];
                cdb_data <= wb_data[gnt_idx*DATA +: DATA];
                cdb_src  <= gnt_idx;
                if (RR != 0)
                    ptr <= (gnt_idx == SW'(CH-1)) ? '0 : gnt_idx + SW'(1);
            end
        end
    end

endmodule

// File: tb/tb_exe_cdb_arb.sv
// ---------------------------------------------------------------------------
// tb_exe_cdb_arb
//   Drives a round-robin and a fixed-priority instance from the same inputs
//   and compares both against a cycle-level model of the arbitration rules.
//   Directed scenarios come first, then randomized requesters that follow
//   the hold-until-ack handshake of the round-robin instance.
// ---------------------------------------------------------------------------
module tb_exe_cdb_arb;

    localparam int DATA = 32;
    localparam int TAG  = 6;
    localparam int CH   = 6;
    localparam int SW   = $clog2(CH);

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [CH-1:0]       wb_req_ = '1;
    logic [CH*TAG-1:0]   wb_tag = '0;
    logic [CH*DATA-1:0]  wb_data = '0;
    logic                cdb_stall = 1'b0;

    logic [CH-1:0]   ack_rr, ack_fp;
    logic            v_rr, v_fp;
    logic [TAG-1:0]  t_rr, t_fp;
    logic [DATA-1:0] d_rr, d_fp;
    logic [SW-1:0]   s_rr, s_fp;

    always #5 clk = ~clk;

    exe_cdb_arb #(.DATA(DATA), .TAG(TAG), .CH(CH), .RR(1)) dut (
        .clk(clk), .reset(reset), .wb_req_(wb_req_), .wb_tag(wb_tag),
        .wb_data(wb_data), .wb_ack_(ack_rr), .cdb_stall(cdb_stall),
        .cdb_valid(v_rr), .cdb_tag(t_rr), .cdb_data(d_rr), .cdb_src(s_rr)
    );

    exe_cdb_arb #(.DATA(DATA), .TAG(TAG), .CH(CH), .RR(0)) dut_fp (
        .clk(clk), .reset(reset), .wb_req_(wb_req_), .wb_tag(wb_tag),
        .wb_data(wb_data), .wb_ack_(ack_fp), .cdb_stall(cdb_stall),
        .cdb_valid(v_fp), .cdb_tag(t_fp), .cdb_data(d_fp), .cdb_src(s_fp)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // model state: index 0 = round-robin instance, 1 = fixed-priority instance
    bit              mv[2];
    logic [TAG-1:0]  mt[2];
    logic [DATA-1:0] md[2];
    int              ms[2];
    int              mp[2];
    int              mg[2];
    bit              mf[2];

    logic [CH-1:0] last_rr, last_fp;
    int n_ack = 0;
    int n_bcast = 0;

    // first requesting channel in the order start, start+1, ..., wrapping
    function automatic int pick(input logic [CH-1:0] req, input int start);
        for (int k = 0; k < CH; k++) begin
            int c;
            c = (start + k) % CH;
            if (req[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [CH-1:0] nack(input int c);
        logic [CH-1:0] v;
        v = '1;
        v[c] = 1'b0;
        return v;
    endfunction

    task automatic set_ch(input int c, input logic [TAG-1:0] t, input logic [DATA-1:0] d);
        wb_req_[c] = 1'b0;
        wb_tag[c*TAG +: TAG] = t;
        wb_data[c*DATA +: DATA] = d;
    endtask

    // One clock: inputs are already set (called at a negedge). Checks the
    // combinational acks, advances the model, checks registered outputs,
    // and returns at the next negedge.
    task automatic cycle();
        logic [CH-1:0] exp_ack[2];
        bit pre_free;
        #1;
        for (int m = 0; m < 2; m++) begin
            exp_ack[m] = '1;
            mg[m] = -1;
            mf[m] = !reset && (!mv[m] || !cdb_stall);
            if (mf[m]) begin
                mg[m] = pick(~wb_req_, (m == 0) ? mp[m] : 0);
                if (mg[m] >= 0) exp_ack[m][mg[m]] = 1'b0;
            end
        end
        chk("ack_rr", ack_rr, exp_ack[0]);
        chk("ack_fp", ack_fp, exp_ack[1]);
        last_rr = ack_rr;
        last_fp = ack_fp;
        n_ack += $countones(~ack_rr);
        pre_free = !reset && (!v_rr || !cdb_stall);
        for (int m = 0; m < 2; m++) begin
            if (reset) begin
                mv[m] = 0; mt[m] = '0; md[m] = '0; ms[m] = 0; mp[m] = 0;
            end else if (mf[m]) begin
                if (mg[m] >= 0) begin
                    mv[m] = 1;
                    mt[m] = wb_tag[mg[m]*TAG +: TAG];
                    md[m] = wb_data[mg[m]*DATA +: DATA];
                    ms[m] = mg[m];
                    mp[m] = (mg[m] + 1) % CH;
                end else begin
                    mv[m] = 0;
                end
            end
        end
        @(posedge clk);
        #1;
        if (pre_free && v_rr) n_bcast++;
        chk("valid_rr", v_rr, mv[0]);
        chk("tag_rr",   t_rr, mt[0]);
        chk("data_rr",  d_rr, md[0]);
        chk("src_rr",   s_rr, ms[0]);
        chk("valid_fp", v_fp, mv[1]);
        chk("tag_fp",   t_fp, mt[1]);
        chk("data_fp",  d_fp, md[1]);
        chk("src_fp",   s_fp, ms[1]);
        @(negedge clk);
    endtask

    task automatic do_reset();
        wb_req_ = '1;
        cdb_stall = 1'b0;
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        int e033[4];
        int cnt[CH];
        e033 = '{0, 2, 5, 0};

        // reset state, including acks forced high while requests are present
        reset = 1'b1;
        cycle();
        wb_req_ = '0;
        cycle();
        chk("rst_ack", last_rr, {CH{1'b1}});
        chk("rst_valid", v_rr, 1'b0);
        chk("rst_src", s_rr, 0);
        do_reset();

        // channels 0, 2, 5 held with tags 3/7/9
        set_ch(0, 6'd3, 32'h100);
        set_ch(2, 6'd7, 32'h102);
        set_ch(5, 6'd9, 32'h105);
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("d033_ack", last_rr, nack(e033[i]));
            chk("d033_src", s_rr, e033[i]);
            chk("d033_tag", t_rr, (e033[i] == 0) ? 3 : (e033[i] == 2) ? 7 : 9);
        end

        // all six requesting for 12 cycles: fair rotation
        do_reset();
        for (int c = 0; c < CH; c++) begin
            set_ch(c, TAG'(c + 10), DATA'(c));
            cnt[c] = 0;
        end
        for (int i = 0; i < 12; i++) begin
            cycle();
            chk("d034_order", last_rr, nack(i % CH));
            for (int c = 0; c < CH; c++) if (!last_rr[c]) cnt[c]++;
        end
        for (int c = 0; c < CH; c++) chk("d034_count", cnt[c], 2);

        // fixed priority: 1 starves 4 until it releases
        wb_req_ = '1;
        set_ch(1, 6'd1, 32'h11);
        set_ch(4, 6'd4, 32'h44);
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("d035_fp_ch1", last_fp, nack(1));
        end
        wb_req_[1] = 1'b1;
        cycle();
        chk("d035_fp_ch4", last_fp, nack(4));
        wb_req_ = '1;
        cycle();

        // stall holds a valid broadcast
        do_reset();
        set_ch(0, 6'd1, 32'hDEADBEEF);
        cycle();
        wb_req_ = '1;
        set_ch(3, 6'd33, 32'h33);
        cdb_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("d036_ack", last_rr, {CH{1'b1}});
            chk("d036_data", d_rr, 32'hDEADBEEF);
            chk("d036_valid", v_rr, 1'b1);
        end
        cdb_stall = 1'b0;
        cycle();
        chk("d036_ack3", last_rr, nack(3));
        chk("d036_data3", d_rr, 32'h33);
        wb_req_ = '1;
        cycle();

        // stall on an idle bus does not block
        cycle();
        cdb_stall = 1'b1;
        set_ch(2, 6'd2, 32'h5);
        cycle();
        chk("d037_ack", last_rr, nack(2));
        chk("d037_data", d_rr, 32'h5);
        chk("d037_valid", v_rr, 1'b1);
        wb_req_ = '1;
        cdb_stall = 1'b0;
        cycle();

        // reset mid-operation with ptr at 4
        do_reset();
        set_ch(3, 6'd3, 32'h3);
        cycle();
        wb_req_ = '1;
        set_ch(4, 6'd4, 32'h4);
        set_ch(5, 6'd5, 32'h5);
        reset = 1'b1;
        cycle();
        chk("d038_ack", last_rr, {CH{1'b1}});
        chk("d038_valid", v_rr, 1'b0);
        chk("d038_data", d_rr, 0);
        chk("d038_src", s_rr, 0);
        reset = 1'b0;
        cycle();
        chk("d038_first", last_rr, nack(4));
        wb_req_ = '1;
        cycle();

        // randomized requesters
        for (int n = 0; n < 3000; n++) begin
            if (reset) reset = 1'b0;
            else if ($urandom_range(99) == 0) reset = 1'b1;
            cdb_stall = ($urandom_range(2) == 0);
            for (int c = 0; c < CH; c++) begin
                if (!wb_req_[c] && !last_rr[c]) begin
                    if ($urandom_range(1) == 1) set_ch(c, TAG'($urandom), DATA'($urandom));
                    else wb_req_[c] = 1'b1;
                end else if (wb_req_[c] && $urandom_range(2) == 0) begin
                    set_ch(c, TAG'($urandom), DATA'($urandom));
                end
            end
            cycle();
        end

        chk("conserve", n_bcast, n_ack);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/exe_cdb_arb.md
EXE_CDB_ARB -- requirements
Module: exe_cdb_arb

Interface
REQ-001 Parameter DATA, default 32: writeback data width per channel.
REQ-002 Parameter TAG, default 6: reorder-buffer tag width.
REQ-003 Parameter CH, default 6: number of execution-unit writeback channels (ALU, DIV, FPU, FDIV, CSR, MEM), legal range 2..16.
REQ-004 Parameter RR, default 1: 1 selects round-robin arbitration, 0 selects fixed priority with the lowest index winning.
REQ-005 One clock; reset is synchronous and active-high.
REQ-006 clk  in  1  clock; all state updates on the rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 wb_req_  in  CH  per-channel writeback request, active-low.
REQ-009 wb_tag  in  CH*TAG  per-channel tag; channel i occupies bits [i*TAG +: TAG].
REQ-010 wb_data  in  CH*DATA  per-channel result; channel i occupies bits [i*DATA +: DATA].
REQ-011 wb_ack_  out  CH  per-channel grant, active-low, combinational, at most one bit low per cycle.
REQ-012 cdb_stall  in  1  consumer back-pressure, active-high.
REQ-013 cdb_valid  out  1  registered common-data-bus valid.
REQ-014 cdb_tag  out  TAG  registered broadcast tag.
REQ-015 cdb_data  out  DATA  registered broadcast data.
REQ-016 cdb_src  out  $clog2(CH)  registered index of the granting channel.

Function
REQ-017 The output stage is free in a cycle when cdb_valid is 0 or cdb_stall is 0.
REQ-018 When the output stage is free and at least one wb_req_ bit is low, exactly one channel is granted: wb_ack_[g] is driven low in that cycle.
REQ-019 When the output stage is not free, all wb_ack_ bits are high and the output registers hold their values.
REQ-020 On the edge following a grant: cdb_valid=1, cdb_tag/cdb_data are loaded from channel g, and cdb_src=g (one-cycle latency from request to broadcast).
REQ-021 When the output stage is free and no request is present: cdb_valid=0 on the next edge, and cdb_tag/cdb_data/cdb_src hold their values.
REQ-022 A requester holds wb_req_ low with stable tag and data until it samples wb_ack_ low; it deasserts on the following cycle or presents a new request.
REQ-023 Each ack_ pulse corresponds to exactly one transfer; no request is dropped or duplicated.
REQ-024 Round-robin mode: a pointer ptr (width $clog2(CH), reset 0) defines the search order ptr, ptr+1, ..., CH-1, 0, ..., ptr-1, and the first requesting channel in that order is granted.
REQ-025 After a grant to g, ptr becomes g+1, wrapping to 0 when g=CH-1; ptr is unchanged in cycles without a grant.
REQ-026 Fixed mode: the lowest-index requesting channel is granted and ptr is unused.
REQ-027 Fairness (RR=1): with all CH channels continuously requesting and no stall, each channel is granted exactly once in every CH consecutive grants.
REQ-028 A stall asserted in the same cycle as cdb_valid=1 blocks a new grant; a stall while cdb_valid=0 does not block a grant.
REQ-029 wb_ack_ is never low for a channel whose wb_req_ is high.

Reset
REQ-030 While reset=1 on an edge: cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_src=0, ptr=0.
REQ-031 While reset=1: wb_ack_ is all ones, regardless of requests.
REQ-032 A request pending when reset is applied mid-operation is not granted; arbitration resumes from ptr=0 on the first cycle after reset deasserts.

Verification
REQ-033 CH=6, RR=1, channels 0, 2 and 5 held requesting with tags 3/7/9, no stall: grants follow 0,2,5,0 with cdb_src 0,2,5,0 and cdb_tag 3,7,9,3, one cycle after each ack.
REQ-034 All 6 channels requesting for 12 cycles, RR=1: each channel is acked exactly twice; the ack order is 0..5,0..5.
REQ-035 RR=0, channels 1 and 4 requesting: channel 1 is acked every cycle and channel 4 is never acked until channel 1 releases its request.
REQ-036 cdb_valid=1 with data 0xDEADBEEF, cdb_stall held high for 3 cycles while channel 3 requests: outputs stay 0xDEADBEEF, wb_ack_[3]=1 throughout; channel 3 is acked in the first cycle after stall falls.
REQ-037 Idle bus, cdb_stall=1, channel 2 requests with data 0x5: wb_ack_[2] goes low immediately and cdb_data=0x5 with cdb_valid=1 on the next edge.
REQ-038 reset pulsed while ptr=4 and channels 4 and 5 are requesting: no ack during reset, outputs zero, and the first grant after reset goes to channel 4 (search starts from ptr=0).
